// File: rtl/digit_enc.sv
// Packed-BCD to binary converter: one digit per clock, most significant first,
// with sticky bad-digit detection and saturation when the value exceeds W bits.
//
// state | meaning
// IDLE  | waiting for start; results from the last conversion are held
// RUN   | folding one digit per edge into the accumulator (acc*10 + d)
module digit_enc #(
  parameter int NDIG = 6,
  parameter int W    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      bin_out,
  output logic              err,
  output logic              ovf
);

  localparam int AW = W + 4;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
  localparam logic [AW-1:0] MAX_VAL  = {4'b0000, {W{1'b1}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [4*NDIG-1:0] sr_q, sr_d;
  logic              flag_q, flag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      bin_q, bin_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic [3:0]        dig;
  logic [AW-1:0]     acc_step;
  logic              step_err;
  logic              step_ovf;

  // Values the current digit would produce; used both mid-run and on the last edge.
  assign dig      = sr_q[4*NDIG-1 -: 4];
  assign acc_step = (acc_q * AW'(10)) + AW'(dig);
  assign step_err = flag_q | (dig > 4'd9);
  assign step_ovf = (acc_step > MAX_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sr_q    <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    flag_d  = flag_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          flag_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_step;
        sr_d   = sr_q << 4;
        flag_d = step_err;
        if (cnt_q == CNT_LAST) begin
          // Bad digits take priority over overflow when choosing bin_out.
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = step_err;
          ovf_d   = step_ovf;
          if (step_err)      bin_d = '0;
          else if (step_ovf) bin_d = '1;
          else               bin_d = acc_step[W-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_digit_enc.sv
// Directed + randomized bench for digit_enc: a default instance and a small
// NDIG=3/W=8 instance, checked against a digit-by-digit arithmetic model.
module tb_digit_enc;

  localparam int ND  = 6;
  localparam int WD  = 20;
  localparam int ND3 = 3;
  localparam int WD3 = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [4*ND-1:0]   bcd_in;
  logic              busy, done, err, ovf;
  logic [WD-1:0]     bin_out;

  logic              start3;
  logic [4*ND3-1:0]  bcd3;
  logic              busy3, done3, err3, ovf3;
  logic [WD3-1:0]    bin3;

  int n_cmp = 0;
  int n_err = 0;

  digit_enc #(.NDIG(ND), .W(WD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err), .ovf(ovf)
  );

  digit_enc #(.NDIG(ND3), .W(WD3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .bin_out(bin3), .err(err3), .ovf(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: read digits MSB first, accumulate value in plain integer arithmetic.
  task automatic ref_model(input logic [63:0] bcd, input int nd, input int w,
                           output logic [63:0] bin, output logic e, output logic o);
    logic [63:0] acc;
    logic [63:0] maxv;
    int d;
    acc  = 0;
    e    = 1'b0;
    maxv = (64'd1 << w) - 64'd1;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'((bcd >> (4 * i)) & 64'hF);
      if (d > 9) e = 1'b1;
      acc = acc * 10 + 64'(d);
    end
    o = (acc > maxv);
    if (e)      bin = 64'd0;
    else if (o) bin = maxv;
    else        bin = acc;
  endtask

  function automatic logic [63:0] rand_bcd(input int nd);
    logic [63:0] v;
    v = 0;
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 7) == 0) v = (v << 4) | 64'($urandom_range(10, 15));
      else                           v = (v << 4) | 64'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic convert(input logic [4*ND-1:0] v, input bit noisy);
    logic [63:0] eb;
    logic ee, eo;
    bit ok;
    ref_model(64'(v), ND, WD, eb, ee, eo);
    start  = 1'b1;
    bcd_in = v;
    tick();
    chk("busy_after_start", 64'(busy), 64'd1);
    ok = 1'b1;
    for (int k = 1; k <= ND; k++) begin
      if (noisy) begin
        start  = 1'($urandom_range(0, 1));
        bcd_in = 24'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      if (k < ND && (busy !== 1'b1 || done !== 1'b0)) ok = 1'b0;
    end
    start = 1'b0;
    chk("run_busy_no_done", 64'(ok), 64'd1);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_cleared", 64'(busy), 64'd0);
    chk("bin_out", 64'(bin_out), eb);
    chk("err", 64'(err), 64'(ee));
    chk("ovf", 64'(ovf), 64'(eo));
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("bin_hold", 64'(bin_out), eb);
  endtask

  task automatic convert3(input logic [4*ND3-1:0] v);
    logic [63:0] eb;
    logic ee, eo;
    ref_model(64'(v), ND3, WD3, eb, ee, eo);
    start3 = 1'b1;
    bcd3   = v;
    tick();
    start3 = 1'b0;
    repeat (ND3 - 1) tick();
    chk("s_not_done_early", 64'(done3), 64'd0);
    tick();
    chk("s_done", 64'(done3), 64'd1);
    chk("s_bin", 64'(bin3), eb);
    chk("s_err", 64'(err3), 64'(ee));
    chk("s_ovf", 64'(ovf3), 64'(eo));
    tick();
    chk("s_done_one_cycle", 64'(done3), 64'd0);
  endtask

  initial begin
    bit ok;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    start3 = 1'b0;
    bcd3   = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bin", 64'(bin_out), 64'd0);
    chk("rst_err_ovf", 64'({err, ovf}), 64'd0);
    #5 rst_n = 1'b1;
    tick();

    convert(24'h123456, 1'b0);
    convert(24'h999999, 1'b0);
    convert(24'h000000, 1'b0);
    convert(24'h12A456, 1'b0);
    convert(24'h000042, 1'b0);

    // Start held high: one result every ND+1 cycles; mid-run input change is ignored.
    start  = 1'b1;
    bcd_in = 24'h000007;
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) bcd_in = 24'h000009;
      if (c == 5) bcd_in = 24'h000007;
      tick();
      chk("b2b_done", 64'(done), 64'((c % 7) == 6));
      chk("b2b_busy", 64'(busy), 64'((c % 7) != 6));
      if ((c % 7) == 6) chk("b2b_bin", 64'(bin_out), 64'd7);
    end
    start = 1'b0;
    tick();
    chk("b2b_idle", 64'({busy, done}), 64'd0);

    for (int i = 0; i < 24; i++) convert(24'(rand_bcd(ND)), 1'b1);

    // Reset mid-run at cnt=3 after a conversion that left nonzero outputs.
    convert(24'h12A999, 1'b0);
    convert(24'h999999, 1'b0);
    start  = 1'b1;
    bcd_in = 24'h777777;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bin", 64'(bin_out), 64'd0);
    chk("abort_err_ovf", 64'({err, ovf}), 64'd0);
    #13 rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("abort_no_done", 64'(ok), 64'd1);
    convert(24'h000100, 1'b0);

    convert3(12'h300);
    convert3(12'h255);
    convert3(12'h256);
    convert3(12'h0B1);
    for (int i = 0; i < 10; i++) convert3(12'(rand_bcd(ND3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digit_enc.md
DIGIT_ENC -- requirements
Module: digit_enc

Interface
REQ-001 SHALL have parameter NDIG, default 6, number of BCD digits per conversion.
REQ-002 SHALL have parameter W, default 20, width of the binary result.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request a conversion of bcd_in.
REQ-006 SHALL have port bcd_in, input, 4*NDIG, packed BCD, most significant digit in bits [4*NDIG-1:4*NDIG-4].
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when bin_out/err/ovf are updated.
REQ-009 SHALL have port bin_out, output, W, binary result of the last completed conversion.
REQ-010 SHALL have port err, output, 1, last conversion contained a digit greater than 9.
REQ-011 SHALL have port ovf, output, 1, last conversion's value exceeded 2^W-1.

Function
REQ-012 SHALL implement FSM with states IDLE and RUN; the digit counter cnt SHALL range 0..NDIG-1.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture bcd_in into an internal shift register, clear the accumulator, clear cnt, set busy=1, and enter RUN.
REQ-014 In RUN, each edge SHALL compute acc <= acc*10 + d, where d is the current top digit; it SHALL then shift the register left by 4 and increment cnt.
REQ-015 The accumulator SHALL be W+4 bits wide so that the multiply-by-10 never wraps internally.
REQ-016 Any digit d > 9 SHALL set a sticky internal error flag for the current conversion; d is still added as its raw value.
REQ-017 On the edge processing digit cnt=NDIG-1, the block SHALL return to IDLE and deassert busy.
REQ-018 On that same edge, the block SHALL register done=1, err=flag, and ovf=(final acc > 2^W-1).
REQ-019 On that same edge, bin_out SHALL be loaded as follows: 0 if err; else all-ones if ovf; else acc[W-1:0].
REQ-020 Latency: start sampled at edge 0; done SHALL be high for exactly the cycle following edge NDIG.
REQ-021 done SHALL be high for exactly one cycle per conversion.
REQ-022 bin_out, err and ovf SHALL hold their values until the next done.
REQ-023 start SHALL be ignored while busy=1; bcd_in changes during RUN SHALL NOT affect the result.
REQ-024 start=1 in the cycle where done=1 (state IDLE) SHALL begin a new conversion, giving back-to-back throughput of one result per NDIG+1 cycles.
REQ-025 With defaults, the maximum input 999999 SHALL yield 0xF423F with ovf=0.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, accumulator=0, shift register=0, busy=0, done=0, bin_out=0, err=0, ovf=0.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; after release the block SHALL be IDLE and accept start on the first edge.
REQ-028 Reset deassertion SHALL require no specific alignment; the first start after release SHALL behave per REQ-013.

Verification
REQ-029 bcd_in=0x123456, start pulse -> busy high for 6 cycles, done pulse at edge 7, bin_out=0x1E240, err=0, ovf=0.
REQ-030 bcd_in=0x999999 -> bin_out=0xF423F, err=0, ovf=0; bcd_in=0x000000 -> bin_out=0, done still pulses.
REQ-031 bcd_in=0x12A456 -> err=1, bin_out=0, ovf=0; a following conversion of 0x000042 -> err=0, bin_out=0x2A.
REQ-032 start held high continuously with bcd_in=0x000007 -> done every 7 cycles, bin_out=7; a mid-RUN change of bcd_in to 0x000009 does not alter the in-flight result.
REQ-033 rst_n pulsed low at RUN cnt=3 -> all outputs 0 immediately, no done pulse; a new start converting 0x000100 -> bin_out=0x64.
REQ-034 Parameter instance NDIG=3, W=8 with bcd_in=0x300 -> ovf=1, bin_out=0xFF; bcd_in=0x255 -> bin_out=0xFF, ovf=0.
